// File: rtl/mem_if_pkg.sv
// -----------------------------------------------------------------------------
// mem_if_pkg
//   Shared definitions for the word-RAM strobe interface. The controller and
//   the RAM both use these defaults.
//   Contents:
//     MEM_DATA_WIDTH : default word width in bits
//     MEM_ADDR_SPACE : default address width (2**MEM_ADDR_SPACE words)
//     state_e        : access controller FSM states
// -----------------------------------------------------------------------------
package mem_if_pkg;

  localparam int MEM_DATA_WIDTH = 32;
  localparam int MEM_ADDR_SPACE = 9;

  // IDLE waits for a request. SETUP presents the address, data and selects.
  // STROBE raises the enable. RECOVER drops the enable and holds the bus.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } state_e;

endpackage : mem_if_pkg

// File: rtl/mem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_if
//   Strobe bus between the access controller (master) and the word RAM
//   (slave). The RAM performs the access on the rising edge of mem_enable.
//   Signals:
//     mem_addr    [ADDR_SPACE] master -> slave  word address
//     mem_datain  [DATA_WIDTH] master -> slave  write data
//     mem_read                 master -> slave  read select
//     mem_write                master -> slave  write select
//     mem_enable               master -> slave  access strobe (rising edge)
//     mem_dataout [DATA_WIDTH] slave -> master  read data
// -----------------------------------------------------------------------------
interface mem_access_ctrl_if
  import mem_if_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int ADDR_SPACE = MEM_ADDR_SPACE
) ();

  logic [ADDR_SPACE-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_datain;
  logic                  mem_read;
  logic                  mem_write;
  logic                  mem_enable;
  logic [DATA_WIDTH-1:0] mem_dataout;

  modport master (
    output mem_addr, mem_datain, mem_read, mem_write, mem_enable,
    input  mem_dataout
  );

  modport slave (
    input  mem_addr, mem_datain, mem_read, mem_write, mem_enable,
    output mem_dataout
  );

endinterface : mem_access_ctrl_if

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Bus-master controller for the on-chip word RAM. It turns a single-cycle
//   load or store request into a SETUP / STROBE / RECOVER sequence on the
//   RAM's edge-triggered strobe bus. Load data goes into a holding register,
//   and a one-cycle done pulse marks completion. Each access takes four cycles.
//   Every bus output comes directly from a flop. There is no combinational
//   path from the request inputs to the bus, so the enable cannot glitch.
//   Ports:
//     clk        in   system clock, rising edge
//     clr        in   asynchronous active-high reset
//     req_read   in   load request, sampled only in IDLE
//     req_write  in   store request, sampled only in IDLE
//     req_addr   in   word address, sampled with the request
//     req_wdata  in   store data, sampled with the request
//     busy       out  high in every state except IDLE
//     done       out  one-cycle completion pulse (in RECOVER)
//     err        out  one-cycle pulse when both requests are seen in IDLE
//     rdata      out  last load result, held until the next load completes
//     mem        if   strobe bus to the RAM (master modport)
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import mem_if_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int ADDR_SPACE = MEM_ADDR_SPACE
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [ADDR_SPACE-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  mem_access_ctrl_if.master     mem
);

  state_e                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  rd_q;
  logic                  wr_q;
  logic                  en_q;
  logic [ADDR_SPACE-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  rdata_en;

  // FSM and all bus and status outputs. A reset clears the enable
  // asynchronously, so an access interrupted during SETUP never strobes.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout. Every flop samples the
      // values from before the edge, whatever the statement order.
      // done and err are pulses. They default low here and are set only in
      // the cycle that raises them.
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_read ^ req_write) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rd_q    <= req_read;
            wr_q    <= req_write;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end else if (req_read && req_write) begin
            err_q <= 1'b1;
          end
        end
        SETUP: begin
          en_q    <= 1'b1;
          state_q <= STROBE;
        end
        STROBE: begin
          en_q    <= 1'b0;
          done_q  <= 1'b1;
          state_q <= RECOVER;
        end
        RECOVER: begin
          // Address and data stay put. Only the selects drop, which keeps
          // hold time after the enable falls.
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Load capture. The RAM drove mem_dataout on the enable rising edge, so
  // the data is stable by the STROBE->RECOVER clock edge.
  assign rdata_en = (state_q == STROBE) && rd_q;
  assign rdata_d  = rdata_en ? mem.mem_dataout : rdata_q;

  // NOTE: rdata is an ordinary holding register, not a RAM array, so it
  // takes a defined reset value.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign rdata          = rdata_q;
  assign mem.mem_addr   = addr_q;
  assign mem.mem_datain = wdata_q;
  assign mem.mem_read   = rd_q;
  assign mem.mem_write  = wr_q;
  assign mem.mem_enable = en_q;

endmodule : mem_access_ctrl

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Self-checking bench for mem_access_ctrl. A behavioural RAM answers the
//   strobe bus. Each accepted request pushes its expected outcome to a
//   scoreboard. A monitor pops an entry on every done pulse and checks it:
//   rdata for a load, RAM contents for a store.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;
  import mem_if_pkg::*;

  localparam int DW    = MEM_DATA_WIDTH;
  localparam int AW    = MEM_ADDR_SPACE;
  localparam int WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          clr;
  logic          req_read;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] rdata;

  mem_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_SPACE(AW)) mem ();

  mem_access_ctrl #(.DATA_WIDTH(DW), .ADDR_SPACE(AW)) dut (
    .clk       (clk),
    .clr       (clr),
    .req_read  (req_read),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem       (mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          is_read;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } sb_t;

  sb_t           sb_q[$];
  logic [DW-1:0] ram     [WORDS];
  logic [DW-1:0] exp_mem [WORDS];

  int n_checks  = 0;
  int n_fail    = 0;
  int cycle     = 0;
  int en_rises  = 0;
  int done_cnt  = 0;
  int last_done = -1;
  bit spacing_on = 1'b0;
  logic prev_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural RAM. It acts on the rising edge of the enable.
  always @(posedge mem.mem_enable) begin
    en_rises++;
    if (mem.mem_write) ram[mem.mem_addr] = mem.mem_datain;
    if (mem.mem_read)  mem.mem_dataout   = ram[mem.mem_addr];
  end

  always @(posedge clk) cycle++;

  // Monitor: bus invariants every cycle, plus a scoreboard pop on done.
  always @(negedge clk) begin
    sb_t e;
    if (clr) begin
      prev_en = 1'b0;
    end else begin
      check("rw_exclusive", 64'(mem.mem_read & mem.mem_write), 64'd0);
      check("enable_one_cycle", 64'(mem.mem_enable & prev_en), 64'd0);
      prev_en = mem.mem_enable;
      if (done) begin
        done_cnt++;
        if (spacing_on && last_done >= 0) check("done_spacing", 64'(cycle - last_done), 64'd4);
        last_done = cycle;
        if (sb_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          if (e.is_read) check("load_rdata", 64'(rdata), 64'(e.data));
          else           check("store_ram", 64'(ram[e.addr]), 64'(e.data));
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_ctrl"}, 64'({busy, done, err, mem.mem_read, mem.mem_write, mem.mem_enable}), 64'd0);
    check({tag, "_rdata"}, 64'(rdata), 64'd0);
    check({tag, "_addr"}, 64'(mem.mem_addr), 64'd0);
    check({tag, "_wdata"}, 64'(mem.mem_datain), 64'd0);
  endtask

  // All tasks assume the caller is positioned just after a falling edge.
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic sb_push(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    sb_t e;
    e.is_read = rd;
    e.addr    = a;
    if (rd) begin
      e.data = exp_mem[a];
    end else begin
      e.data     = d;
      exp_mem[a] = d;
    end
    sb_q.push_back(e);
  endtask

  // Request for one cycle. Returns at the falling edge after the sampling edge.
  task automatic drive_req(input logic rd, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    req_read  = rd;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_read  = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic issue(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_idle();
    sb_push(rd, a, d);
    drive_req(rd, !rd, a, d);
  endtask

  // {busy, mem_write, mem_read, mem_enable, done, err} after E0..E3 of a store
  logic [5:0] store_tab [4] = '{6'b110000, 6'b110100, 6'b110010, 6'b000000};

  initial begin
    int r0;
    int d0;
    int n;
    for (int i = 0; i < WORDS; i++) begin
      ram[i]     = DW'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
      exp_mem[i] = DW'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
    end
    clr = 1'b1; req_read = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    clr = 1'b0;
    @(negedge clk);

    // Store with per-cycle bus timing
    wait_idle();
    sb_push(1'b0, 9'h010, 32'hDEAD_BEEF);
    drive_req(1'b0, 1'b1, 9'h010, 32'hDEAD_BEEF);
    check("store_addr", 64'(mem.mem_addr), 64'h010);
    check("store_data", 64'(mem.mem_datain), 64'hDEAD_BEEF);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("store_seq_%0d", k),
            64'({busy, mem.mem_write, mem.mem_read, mem.mem_enable, done, err}),
            64'(store_tab[k]));
    end
    check("store_ram_010", 64'(ram[9'h010]), 64'hDEAD_BEEF);

    // Load after store, then a store must leave rdata alone
    issue(1'b1, 9'h010, '0);
    issue(1'b0, 9'h020, 32'h1234_5678);
    wait_idle();
    check("rdata_held", 64'(rdata), 64'hDEAD_BEEF);

    // Conflict
    r0 = en_rises;
    drive_req(1'b1, 1'b1, 9'h040, 32'h0000_0055);
    check("conflict_err", 64'({err, busy, mem.mem_enable}), 64'b100);
    @(negedge clk);
    check("conflict_err_pulse", 64'({err, busy}), 64'd0);
    check("conflict_ram", 64'(ram[9'h040]), 64'(exp_mem[9'h040]));
    check("conflict_no_strobe", 64'(en_rises - r0), 64'd0);

    // Busy drop A: load request held during SETUP..RECOVER, gone by IDLE
    r0 = en_rises;
    wait_idle();
    sb_push(1'b0, 9'h050, 32'h0BAD_F00D);
    drive_req(1'b0, 1'b1, 9'h050, 32'h0BAD_F00D);
    req_read = 1'b1; req_addr = 9'h060;
    @(negedge clk);
    @(negedge clk);
    req_read = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_drop_ignored", 64'(en_rises - r0), 64'd1);
    check("busy_drop_idle", 64'(busy), 64'd0);

    // Busy drop B: load request held until IDLE, accepted at E4
    r0 = en_rises;
    sb_push(1'b0, 9'h070, 32'h7777_0000);
    drive_req(1'b0, 1'b1, 9'h070, 32'h7777_0000);
    req_read = 1'b1; req_addr = 9'h010;
    repeat (3) @(negedge clk);
    sb_push(1'b1, 9'h010, '0);
    @(negedge clk);
    req_read = 1'b0;
    check("held_req_accepted", 64'({busy, mem.mem_read}), 64'b11);
    wait_idle();
    check("held_req_strobes", 64'(en_rises - r0), 64'd2);

    // Reset during SETUP of a store: never issued, no done
    r0 = en_rises; d0 = done_cnt;
    wait_idle();
    drive_req(1'b0, 1'b1, 9'h030, 32'hCAFE_F00D);
    #2 clr = 1'b1;
    #1 check_reset_state("clr_setup");
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    repeat (4) @(negedge clk);
    check("clr_setup_ram", 64'(ram[9'h030]), 64'(exp_mem[9'h030]));
    check("clr_setup_no_strobe", 64'(en_rises - r0), 64'd0);
    check("clr_setup_no_done", 64'(done_cnt - d0), 64'd0);

    // Reset during RECOVER of a load: outputs clear immediately
    issue(1'b1, 9'h020, '0);
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("recover_reached", 64'(done), 64'd1);
    #2 clr = 1'b1;
    #1 check_reset_state("clr_recover");
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    // Back-to-back loads of 0x000..0x007
    d0 = done_cnt;
    last_done = -1;
    spacing_on = 1'b1;
    for (int i = 0; i < 8; i++) issue(1'b1, AW'(i), '0);
    wait_idle();
    spacing_on = 1'b0;
    check("b2b_done_count", 64'(done_cnt - d0), 64'd8);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule : tb_mem_access_ctrl

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Bus-master controller that drives the on-chip word RAM's strobe interface (read, write, enable, address, write data) on behalf of the CPU control unit. It turns a single-cycle load/store request into the RAM's edge-triggered enable protocol and captures read data into a holding register. It reports completion with a one-cycle done pulse. It sits between the control unit/MAR-MDR datapath and the RAM.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDR_SPACE, 9, address width (512 words)

- clk  input  1  system clock, rising edge
- clr  input  1  asynchronous, active-high reset
- req_read  input  1  load request, sampled only in IDLE
- req_write  input  1  store request, sampled only in IDLE
- req_addr  input  ADDR_SPACE  word address, sampled with request
- req_wdata  input  DATA_WIDTH  store data, sampled with request
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle pulse: req_read and req_write both high in IDLE
- rdata  output  DATA_WIDTH  last load result, held until the next load completes
- mem_addr  output  ADDR_SPACE  to RAM address
- mem_datain  output  DATA_WIDTH  to RAM write data
- mem_read  output  1  to RAM read select
- mem_write  output  1  to RAM write select
- mem_enable  output  1  to RAM enable; the RAM acts on its rising edge
- mem_dataout  input  DATA_WIDTH  from RAM read data

## Operation
- FSM states: IDLE, SETUP, STROBE, RECOVER.
- IDLE, exactly one of req_read/req_write high at a clk edge:
  - Latch req_addr into mem_addr and req_wdata into mem_datain.
  - Set mem_read or mem_write to match the request.
  - Go to SETUP.
- IDLE, both requests high: no access, err=1 for one cycle, stay in IDLE.
- IDLE, neither request high: stay in IDLE.
- SETUP: mem_enable=0; address, data and selects are stable. Go to STROBE.
- STROBE: mem_enable=1. The rising edge comes from the register, so the RAM performs the access at that point. Go to RECOVER.
- RECOVER:
  - mem_enable=0 and done=1.
  - For a load, rdata captured mem_dataout on the STROBE→RECOVER edge.
  - mem_addr, mem_datain, mem_read and mem_write are still held, giving hold time after enable falls.
  - Go to IDLE.
- On the RECOVER→IDLE edge, mem_read and mem_write clear to 0. mem_addr and mem_datain keep their values.
- A store never modifies rdata.
- Requests arriving while busy=1 are ignored. They are not queued.
- Reset values: state=IDLE, busy=0, done=0, err=0, rdata=0, mem_addr=0, mem_datain=0, mem_read=0, mem_write=0, mem_enable=0.
- clr asserted mid-operation:
  - All outputs go immediately to their reset values; mem_enable falls without waiting for clk.
  - A store whose STROBE edge has already occurred has completed in the RAM.
  - A store reset during SETUP has not been issued.
  - No done is produced for an aborted access.

## Timing
- Request sampled at edge E0. SETUP runs E0–E1, STROBE E1–E2, RECOVER E2–E3 (done high), IDLE from E3.
- Next request can be accepted at E4. Throughput is one access per 4 cycles.
- Load latency: rdata is valid in the same cycle done is high (after E2).
- Every memory-side output comes directly from a flop. No combinational path exists from request inputs to mem_*, so the enable is glitch-free.
- mem_enable is high for exactly one clk period per access.
- mem_read and mem_write are never both 1.

## Structure
- Shared package mem_if_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, RECOVER);
  - the default DATA_WIDTH/ADDR_SPACE constants, shared with the RAM.
- Single module, no sub-module. The FSM and output registers share one always block with async clr; rdata is a separate enabled register.

## Test plan
- Store: req_write, addr 0x010, data 0xDEADBEEF at E0 → mem_write=1 from E0 through E3, mem_enable high only E1–E2, done at E2–E3, no err, RAM word 0x010 = 0xDEADBEEF.
- Load after store: req_read addr 0x010 → rdata=0xDEADBEEF while done=1; rdata still 0xDEADBEEF after a subsequent store of 0x12345678 to 0x020.
- Conflict: req_read=req_write=1 in IDLE → err one cycle, mem_enable stays 0, busy stays 0, RAM unchanged.
- Busy drop: second request held during SETUP/STROBE/RECOVER → ignored; accepted only when asserted in IDLE, and only if still present at that edge.
- Reset mid-access: clr during SETUP of a store to 0x030 → mem_enable never rises, RAM 0x030 unchanged, no done. clr during RECOVER → all outputs at reset values immediately.
- Back-to-back: loads of 0x000–0x007 issued as soon as busy drops → exactly 8 done pulses, 4 cycles apart, with correct rdata each.
